msg_peek_fifo: RTL and testbench

//   Parametrised successor to the CPU's fixed 4-entry, 2-bit-type message FIFO. Stores typed

---
 rtl/msg_peek_fifo_pkg.sv | 13 +
 rtl/msg_peek_fifo.sv | 119 +++++++++++
 tb/tb_msg_peek_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/msg_peek_fifo_pkg.sv
// Shared message-type codes and the default type-tag width, so the FIFO and
// the decoder agree on the encoding.
package msg_peek_fifo_pkg;

  localparam int MSG_TYPE_BITS_DEF = 2;

  // Type 0 marks an empty slot; the FIFO keeps every unused slot at this value.
  localparam logic [MSG_TYPE_BITS_DEF-1:0] MSG_NONE = 2'd0;
  localparam logic [MSG_TYPE_BITS_DEF-1:0] MSG_OP   = 2'd1;
  localparam logic [MSG_TYPE_BITS_DEF-1:0] MSG_IMM  = 2'd2;
  localparam logic [MSG_TYPE_BITS_DEF-1:0] MSG_ADDR = 2'd3;

endpackage

// File: rtl/msg_peek_fifo.sv
// Typed-word FIFO between prefetch and decoder. Shift-register ordered:
// entries[0] is always the head. The oldest PEEK entries are visible at once
// and the consumer retires 0..PEEK of them per cycle. Flush drops everything.
module msg_peek_fifo
  import msg_peek_fifo_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int DATA_BITS     = 16,
  parameter int MSG_TYPE_BITS = MSG_TYPE_BITS_DEF,
  parameter int PEEK          = 2,
  localparam int CNT_W        = $clog2(DEPTH + 1),
  localparam int CONS_W       = $clog2(PEEK + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MSG_TYPE_BITS-1:0]       in_type,
  input  logic [DATA_BITS-1:0]           in_data,
  output logic [PEEK*MSG_TYPE_BITS-1:0]  out_type,
  output logic [PEEK*DATA_BITS-1:0]      out_data,
  input  logic [CONS_W-1:0]              consume,
  output logic [CNT_W-1:0]               count,
  output logic                           underflow
);

  // Flat storage, kept as plain arrays so benches can probe them.
  logic [MSG_TYPE_BITS-1:0] entries_type [DEPTH];
  logic [DATA_BITS-1:0]     entries_data [DEPTH];

  logic [DEPTH-1:0][MSG_TYPE_BITS-1:0] type_nxt;
  logic [DEPTH-1:0][DATA_BITS-1:0]     data_nxt;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] retire;
  logic [CNT_W-1:0] ins_idx;
  logic             push;
  logic             over;
  logic             underflow_q;

  // in_ready depends only on the registered count: a full FIFO never takes a
  // word in the same cycle it retires one.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign count     = count_q;
  assign underflow = underflow_q;

  // Clamp the retire amount to what is stored and find the insert slot.
  always_comb begin
    over      = 32'(consume) > 32'(count_q);
    retire    = over ? count_q : CNT_W'(consume);
    push      = in_valid & in_ready & ~flush;
    ins_idx   = count_q - retire;
    count_nxt = flush ? '0 : ins_idx + CNT_W'(push);
  end

  // Per-slot mux: keep a shifted-down survivor, take the new word at the
  // insert slot, otherwise zero so empty slots always read as MSG_NONE.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [MSG_TYPE_BITS-1:0] t_n;
    logic [DATA_BITS-1:0]     d_n;

    // Next value of slot i.
    always_comb begin
      t_n = '0;
      d_n = '0;
      if (!flush) begin
        if (CNT_W'(i) < ins_idx) begin
          // Survivor: i + retire < count <= DEPTH, so the guard only trims
          // shift amounts that can never select this slot.
          for (int k = 0; k <= PEEK; k++) begin
            if (retire == CNT_W'(k) && (i + k) < DEPTH) begin
              t_n = entries_type[(i + k) % DEPTH];
              d_n = entries_data[(i + k) % DEPTH];
            end
          end
        end else if (push && ins_idx == CNT_W'(i)) begin
          t_n = in_type;
          d_n = in_data;
        end
      end
    end

    assign type_nxt[i] = t_n;
    assign data_nxt[i] = d_n;
  end

  // All state: entries, count and the sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_type[i] <= '0;
        entries_data[i] <= '0;
      end
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_type[i] <= type_nxt[i];
        entries_data[i] <= data_nxt[i];
      end
      count_q <= count_nxt;
      if (!flush && over) underflow_q <= 1'b1;
    end
  end

  // Peek window: the oldest PEEK slots straight from the registers.
  for (genvar i = 0; i < PEEK; i++) begin : g_out
    assign out_type[i*MSG_TYPE_BITS +: MSG_TYPE_BITS] = entries_type[i];
    assign out_data[i*DATA_BITS +: DATA_BITS]         = entries_data[i];
  end

  // A pushed word must carry a real type; type 0 would read as an empty slot.
  a_push_type_nonzero: assert property (
    @(posedge clk) disable iff (!rst_n) push |-> (in_type != MSG_NONE)
  );

endmodule

// File: tb/tb_msg_peek_fifo.sv
// Scoreboard bench: the stimulus side steps a queue model and pushes the
// expected post-edge view; a negedge monitor pops and compares.
// Instance a uses default parameters (directed cases), instance b uses
// DEPTH=8, PEEK=3, DATA_BITS=8 (random traffic with a mid-burst reset).
module tb_msg_peek_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: DEPTH 4, DATA 16, PEEK 2
  logic        a_flush, a_in_valid, a_in_ready, a_underflow;
  logic [1:0]  a_in_type, a_consume;
  logic [15:0] a_in_data;
  logic [3:0]  a_out_type;
  logic [31:0] a_out_data;
  logic [2:0]  a_count;

  // Instance b: DEPTH 8, DATA 8, PEEK 3
  logic        b_flush, b_in_valid, b_in_ready, b_underflow;
  logic [1:0]  b_in_type, b_consume;
  logic [7:0]  b_in_data;
  logic [5:0]  b_out_type;
  logic [23:0] b_out_data;
  logic [3:0]  b_count;

  msg_peek_fifo dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_type(a_in_type), .in_data(a_in_data),
    .out_type(a_out_type), .out_data(a_out_data),
    .consume(a_consume), .count(a_count), .underflow(a_underflow)
  );

  msg_peek_fifo #(.DEPTH(8), .DATA_BITS(8), .MSG_TYPE_BITS(2), .PEEK(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_type(b_in_type), .in_data(b_in_data),
    .out_type(b_out_type), .out_data(b_out_data),
    .consume(b_consume), .count(b_count), .underflow(b_underflow)
  );

  typedef struct packed {
    logic             sel;
    logic [3:0]       cnt;
    logic             uf;
    logic             rdy;
    logic [2:0][1:0]  t;
    logic [2:0][15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   mq_t[$];
  int   mq_d[$];
  int   m_uf;
  int   sel;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic int depth_of(input int s);
    return s ? 8 : 4;
  endfunction

  function automatic int peek_of(input int s);
    return s ? 3 : 2;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic idle();
    a_flush = 0; a_in_valid = 0; a_in_type = 0; a_in_data = 0; a_consume = 0;
    b_flush = 0; b_in_valid = 0; b_in_type = 0; b_in_data = 0; b_consume = 0;
  endtask

  // One clock of traffic on the selected instance, plus the model update.
  task automatic step(input int iv, input int ty, input int dat, input int cons, input int fl);
    exp_t e;
    int   acc;
    int   c;
    if (sel == 0) begin
      a_in_valid = iv[0]; a_in_type = 2'(ty); a_in_data = 16'(dat);
      a_consume = 2'(cons); a_flush = fl[0];
    end else begin
      b_in_valid = iv[0]; b_in_type = 2'(ty); b_in_data = 8'(dat);
      b_consume = 2'(cons); b_flush = fl[0];
    end
    @(posedge clk);
    acc = (iv != 0 && mq_t.size() != depth_of(sel) && fl == 0) ? 1 : 0;
    if (fl != 0) begin
      mq_t.delete();
      mq_d.delete();
    end else begin
      if (cons > mq_t.size()) m_uf = 1;
      c = (cons > mq_t.size()) ? mq_t.size() : cons;
      repeat (c) begin
        void'(mq_t.pop_front());
        void'(mq_d.pop_front());
      end
      if (acc != 0) begin
        mq_t.push_back(ty);
        mq_d.push_back(sel ? (dat & 'hff) : (dat & 'hffff));
      end
    end
    e     = '0;
    e.sel = sel[0];
    e.cnt = 4'(mq_t.size());
    e.uf  = m_uf[0];
    e.rdy = (mq_t.size() != depth_of(sel));
    for (int i = 0; i < 3; i++) begin
      if (i < mq_t.size()) begin
        e.t[i] = 2'(mq_t[i]);
        e.d[i] = 16'(mq_d[i]);
      end
    end
    exp_q.push_back(e);
    #1;
    idle();
  endtask

  // Async reset away from the clock edge; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    if (sel == 0) begin
      chk("rst_count_a", 32'(a_count), 0);
      chk("rst_ready_a", 32'(a_in_ready), 1);
      chk("rst_uflow_a", 32'(a_underflow), 0);
      chk("rst_slot0_a", {a_out_type[1:0], a_out_data[15:0]}, 0);
    end else begin
      chk("rst_count_b", 32'(b_count), 0);
      chk("rst_ready_b", 32'(b_in_ready), 1);
      chk("rst_uflow_b", 32'(b_underflow), 0);
      chk("rst_slot0_b", {b_out_type[1:0], b_out_data[7:0]}, 0);
    end
    mq_t.delete();
    mq_d.delete();
    m_uf  = 0;
    rst_n = 1'b1;
  endtask

  // Monitor: compare the DUT against each expected post-edge view.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.sel == 1'b0) begin
        chk("count", 32'(a_count), 32'(e.cnt));
        chk("underflow", 32'(a_underflow), 32'(e.uf));
        chk("in_ready", 32'(a_in_ready), 32'(e.rdy));
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("slot%0d_type", i), 32'(a_out_type[i*2 +: 2]), 32'(e.t[i]));
          chk($sformatf("slot%0d_data", i), 32'(a_out_data[i*16 +: 16]), 32'(e.d[i]));
        end
      end else begin
        chk("count_b", 32'(b_count), 32'(e.cnt));
        chk("underflow_b", 32'(b_underflow), 32'(e.uf));
        chk("in_ready_b", 32'(b_in_ready), 32'(e.rdy));
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("b_slot%0d_type", i), 32'(b_out_type[i*2 +: 2]), 32'(e.t[i]));
          chk($sformatf("b_slot%0d_data", i), 32'(b_out_data[i*8 +: 8]), 32'(e.d[i] & 16'hff));
        end
      end
    end
  end

  initial begin
    int r;
    int cons;
    idle();
    m_uf = 0;
    sel  = 0;
    do_reset();

    // Fill three, then the fourth; then a full push with consume=1 is refused.
    step(1, 1, 'h1111, 0, 0);
    step(1, 2, 'h2222, 0, 0);
    step(1, 3, 'h3333, 0, 0);
    step(1, 1, 'h4444, 0, 0);
    step(1, 2, 'h5555, 1, 0);
    step(1, 2, 'h5555, 0, 0);
    // Down to two, then consume two with a same-cycle push.
    step(0, 0, 0, 2, 0);
    step(1, 3, 'hABCD, 2, 0);
    // One left, consume two: underflow and it stays set.
    step(0, 0, 0, 2, 0);
    step(1, 1, 'h0101, 0, 0);
    step(1, 2, 'h0202, 1, 0);
    step(1, 3, 'h0303, 0, 0);
    step(1, 1, 'h0404, 0, 0);
    // Three stored, flush with push and consume in the same cycle.
    step(1, 2, 'h7777, 1, 1);
    step(0, 0, 0, 0, 0);
    // Reset clears the sticky flag; first push right after release lands.
    do_reset();
    step(1, 3, 'h9999, 0, 0);
    step(0, 0, 0, 1, 0);

    // Random traffic on the larger instance.
    sel = 1;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) do_reset();
      r    = $urandom_range(0, 7);
      cons = (r < 3) ? 0 : (r < 5) ? 1 : (r < 7) ? 2 : 3;
      step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(1, 3),
           $urandom_range(0, 255), cons, ($urandom_range(0, 31) == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
